// File: rtl/tea_pkg.sv
// ---------------------------------------------------------------------------
// tea_pkg
// Shared constants and helper functions for the pipelined TEA datapath.
//   TEA_DELTA : TEA key-schedule constant.
//   tea_f     : TEA mixing function F(x, s, ka, kb).
//   tea_sum   : elaboration-time round sum for global cycle g, either mode.
// ---------------------------------------------------------------------------
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    function automatic logic [31:0] tea_f(input logic [31:0] x,
                                          input logic [31:0] s,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    // Encrypt walks the sum upward from DELTA; decrypt walks it back down
    // from DELTA*ROUNDS, so cycle g of a decrypt undoes cycle ROUNDS-1-g.
    function automatic logic [31:0] tea_sum(input int   g,
                                            input int   rounds,
                                            input logic decrypt);
        logic [31:0] mult;
        mult = decrypt ? 32'(rounds - g) : 32'(g + 1);
        return TEA_DELTA * mult;
    endfunction

endpackage

// File: rtl/tea_round.sv
// ---------------------------------------------------------------------------
// tea_round
// One TEA cycle (a v0 half-round plus a v1 half-round), purely
// combinational. Both directions are built; decrypt selects the result.
// The round sums are elaboration-time constants.
//   v0, v1          in  32   block entering this cycle
//   key             in  128  k0=[31:0] k1=[63:32] k2=[95:64] k3=[127:96]
//   decrypt         in  1    0 = encrypt, 1 = decrypt
//   res_v0, res_v1  out 32   block leaving this cycle
// ---------------------------------------------------------------------------
module tea_round
    import tea_pkg::*;
#(
    parameter logic [31:0] SUM_ENC = TEA_DELTA,
    parameter logic [31:0] SUM_DEC = TEA_DELTA
) (
    input  logic [31:0]  v0,
    input  logic [31:0]  v1,
    input  logic [127:0] key,
    input  logic         decrypt,
    output logic [31:0]  res_v0,
    output logic [31:0]  res_v1
);

    logic [31:0] k0, k1, k2, k3;
    logic [31:0] enc_v0, enc_v1;
    logic [31:0] dec_v0, dec_v1;

    assign k0 = key[31:0];
    assign k1 = key[63:32];
    assign k2 = key[95:64];
    assign k3 = key[127:96];

    // Encrypt updates v0 first, then v1 from the new v0.
    assign enc_v0 = v0 + tea_f(v1, SUM_ENC, k0, k1);
    assign enc_v1 = v1 + tea_f(enc_v0, SUM_ENC, k2, k3);

    // Decrypt reverses the order: v1 first, then v0 from the new v1.
    assign dec_v1 = v1 - tea_f(v0, SUM_DEC, k2, k3);
    assign dec_v0 = v0 - tea_f(dec_v1, SUM_DEC, k0, k1);

    assign res_v0 = decrypt ? dec_v0 : enc_v0;
    assign res_v1 = decrypt ? dec_v1 : enc_v1;

endmodule

// File: rtl/tea_pipe_ed.sv
// ---------------------------------------------------------------------------
// tea_pipe_ed
// Fully pipelined TEA encrypt/decrypt engine. ROUNDS TEA cycles are split
// into STAGES = ROUNDS/RPS register ranks of RPS unrolled cycles each. Mode,
// key and tag travel with each transaction. A single global advance enable
// stalls every rank when the output is held.
//   clk, nrst                  clock, synchronous active-low reset
//   in_valid / in_ready        input handshake (in_ready = advance)
//   in_decrypt, in_tag         mode and opaque sideband
//   in_v0, in_v1, in_key       block and 128-bit key
//   out_valid / out_ready      output handshake
//   out_decrypt, out_tag       mode and tag of the result
//   out_v0, out_v1             result block
// ---------------------------------------------------------------------------
module tea_pipe_ed
    import tea_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int RPS    = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_decrypt,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_v0,
    input  logic [31:0]      in_v1,
    input  logic [127:0]     in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_decrypt,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_v0,
    output logic [31:0]      out_v1
);

    localparam int STAGES = (RPS > 0) ? ROUNDS / RPS : 1;

    if ((ROUNDS < 1) || (RPS < 1) || ((ROUNDS % RPS) != 0)) begin : g_bad_cfg
        $error("tea_pipe_ed: ROUNDS must be >= 1 and an exact multiple of RPS");
    end

    // Rank registers
    logic             vld_p [STAGES];
    logic             dec_p [STAGES];
    logic [TAG_W-1:0] tag_p [STAGES];
    logic [31:0]      v0_p  [STAGES];
    logic [31:0]      v1_p  [STAGES];
    logic [127:0]     key_p [STAGES];

    // Combinational result of each stage, captured by the matching rank
    logic [31:0]      nv0   [STAGES];
    logic [31:0]      nv1   [STAGES];

    logic             adv;

    // Holding the last rank freezes the whole pipe; bubbles are kept.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [31:0]  sv0, sv1;
        logic [127:0] skey;
        logic         sdec;

        if (s == 0) begin : g_src_in
            assign sv0  = in_v0;
            assign sv1  = in_v1;
            assign skey = in_key;
            assign sdec = in_decrypt;
        end else begin : g_src_rank
            assign sv0  = v0_p[s-1];
            assign sv1  = v1_p[s-1];
            assign skey = key_p[s-1];
            assign sdec = dec_p[s-1];
        end

        for (genvar r = 0; r < RPS; r++) begin : g_round
            logic [31:0] iv0, iv1, ov0, ov1;

            if (r == 0) begin : g_first
                assign iv0 = sv0;
                assign iv1 = sv1;
            end else begin : g_next
                assign iv0 = g_round[r-1].ov0;
                assign iv1 = g_round[r-1].ov1;
            end

            tea_round #(
                .SUM_ENC (tea_sum(s * RPS + r, ROUNDS, 1'b0)),
                .SUM_DEC (tea_sum(s * RPS + r, ROUNDS, 1'b1))
            ) u_round (
                .v0      (iv0),
                .v1      (iv1),
                .key     (skey),
                .decrypt (sdec),
                .res_v0  (ov0),
                .res_v1  (ov1)
            );
        end

        assign nv0[s] = g_round[RPS-1].ov0;
        assign nv1[s] = g_round[RPS-1].ov1;
    end

    // Rank boundary: every rank shifts together on adv. Reset clears the
    // valids and the data of the last rank, which drives the out_* ports.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_p[i] <= 1'b0;
            end
            dec_p[STAGES-1] <= 1'b0;
            tag_p[STAGES-1] <= '0;
            v0_p[STAGES-1]  <= '0;
            v1_p[STAGES-1]  <= '0;
        end else if (adv) begin
            vld_p[0] <= in_valid;
            dec_p[0] <= in_decrypt;
            tag_p[0] <= in_tag;
            key_p[0] <= in_key;
            for (int i = 1; i < STAGES; i++) begin
                vld_p[i] <= vld_p[i-1];
                dec_p[i] <= dec_p[i-1];
                tag_p[i] <= tag_p[i-1];
                key_p[i] <= key_p[i-1];
            end
            for (int i = 0; i < STAGES; i++) begin
                v0_p[i] <= nv0[i];
                v1_p[i] <= nv1[i];
            end
        end
    end

    assign out_valid   = vld_p[STAGES-1];
    assign out_decrypt = dec_p[STAGES-1];
    assign out_tag     = tag_p[STAGES-1];
    assign out_v0      = v0_p[STAGES-1];
    assign out_v1      = v1_p[STAGES-1];

endmodule

// File: tb/tb_tea_pipe_ed.sv
// ---------------------------------------------------------------------------
// tb_tea_pipe_ed
// Scoreboard bench for tea_pipe_ed: expectations are queued at each input
// handshake and compared in order at each output handshake. Three extra
// instances cover other (ROUNDS, RPS) configurations.
// ---------------------------------------------------------------------------
module tb_tea_pipe_ed;

    localparam int STG = 32;
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    typedef struct {
        logic        dec;
        logic [3:0]  tag;
        logic [31:0] v0;
        logic [31:0] v1;
        int          hs;
    } exp_t;

    logic         clk;
    logic         nrst;
    logic         in_valid, in_ready, in_decrypt;
    logic [3:0]   in_tag;
    logic [31:0]  in_v0, in_v1;
    logic [127:0] in_key;
    logic         out_valid, out_ready, out_decrypt;
    logic [3:0]   out_tag;
    logic [31:0]  out_v0, out_v1;

    logic         sw_valid;
    logic         sw_vld [3];
    logic         sw_rdy [3];
    logic         sw_dec [3];
    logic [3:0]   sw_tag [3];
    logic [31:0]  sw_v0  [3];
    logic [31:0]  sw_v1  [3];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_hs = 0;
    logic chk_lat = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tea_pipe_ed #(.ROUNDS(32), .RPS(1), .TAG_W(4)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
        .in_tag(in_tag), .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_decrypt(out_decrypt),
        .out_tag(out_tag), .out_v0(out_v0), .out_v1(out_v1)
    );

    tea_pipe_ed #(.ROUNDS(32), .RPS(4), .TAG_W(4)) sw0 (
        .clk(clk), .nrst(nrst),
        .in_valid(sw_valid), .in_ready(sw_rdy[0]), .in_decrypt(in_decrypt),
        .in_tag(in_tag), .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
        .out_valid(sw_vld[0]), .out_ready(1'b1), .out_decrypt(sw_dec[0]),
        .out_tag(sw_tag[0]), .out_v0(sw_v0[0]), .out_v1(sw_v1[0])
    );

    tea_pipe_ed #(.ROUNDS(16), .RPS(16), .TAG_W(4)) sw1 (
        .clk(clk), .nrst(nrst),
        .in_valid(sw_valid), .in_ready(sw_rdy[1]), .in_decrypt(in_decrypt),
        .in_tag(in_tag), .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
        .out_valid(sw_vld[1]), .out_ready(1'b1), .out_decrypt(sw_dec[1]),
        .out_tag(sw_tag[1]), .out_v0(sw_v0[1]), .out_v1(sw_v1[1])
    );

    tea_pipe_ed #(.ROUNDS(1), .RPS(1), .TAG_W(4)) sw2 (
        .clk(clk), .nrst(nrst),
        .in_valid(sw_valid), .in_ready(sw_rdy[2]), .in_decrypt(in_decrypt),
        .in_tag(in_tag), .in_v0(in_v0), .in_v1(in_v1), .in_key(in_key),
        .out_valid(sw_vld[2]), .out_ready(1'b1), .out_decrypt(sw_dec[2]),
        .out_tag(sw_tag[2]), .out_v0(sw_v0[2]), .out_v1(sw_v1[2])
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // Reference TEA written in the usual C-loop form.
    function automatic logic [63:0] tea_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [127:0] k, input logic dec,
                                              input int rounds);
        logic [31:0] y, z, sum, k0, k1, k2, k3;
        y = a; z = b;
        k0 = k[31:0]; k1 = k[63:32]; k2 = k[95:64]; k3 = k[127:96];
        if (!dec) begin
            sum = 32'd0;
            for (int i = 0; i < rounds; i++) begin
                sum = sum + DELTA;
                y = y + (((z << 4) + k0) ^ (z + sum) ^ ((z >> 5) + k1));
                z = z + (((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3));
            end
        end else begin
            sum = DELTA * 32'(rounds);
            for (int i = 0; i < rounds; i++) begin
                z = z - (((y << 4) + k2) ^ (y + sum) ^ ((y >> 5) + k3));
                y = y - (((z << 4) + k0) ^ (z + sum) ^ ((z >> 5) + k1));
                sum = sum - DELTA;
            end
        end
        return {y, z};
    endfunction

    task automatic send(input logic dec, input logic [3:0] tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [127:0] k,
                        input logic [31:0] e0, input logic [31:0] e1);
        int   w;
        exp_t e;
        in_valid = 1'b1; in_decrypt = dec; in_tag = tag;
        in_v0 = a; in_v1 = b; in_key = k;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1'b1);
        end else begin
            e.dec = dec; e.tag = tag; e.v0 = e0; e.v1 = e1; e.hs = cyc;
            sb.push_back(e);
            last_hs = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_rand(input logic dec);
        logic [31:0]  a, b;
        logic [127:0] k;
        logic [63:0]  r;
        a = $urandom; b = $urandom;
        k = {$urandom, $urandom, $urandom, $urandom};
        r = tea_model(a, b, k, dec, STG);
        send(dec, 4'($urandom_range(15)), a, b, k, r[63:32], r[31:0]);
    endtask

    task automatic drain();
        int w;
        w = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Output side of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (nrst) begin
            if (sb.size() == 0) begin
                chk("no_spurious_out", out_valid, 1'b0);
            end else if (out_valid && out_ready) begin
                e = sb.pop_front();
                chk("out_v0", out_v0, e.v0);
                chk("out_v1", out_v1, e.v1);
                chk("out_tag", out_tag, e.tag);
                chk("out_decrypt", out_decrypt, e.dec);
                if (chk_lat) chk("latency", 64'(cyc - e.hs), 64'(STG));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  pat;
        logic [31:0] snap_v0, snap_v1;
        logic [3:0]  snap_tag;
        logic [31:0] p0, p1;
        logic [127:0] k;
        logic [63:0] c;
        int          h, w;
        int          sw_rounds [3];
        int          sw_lat [3];
        int          seen_n [3];
        int          seen_cyc [3];
        logic [63:0] seen_d [3];
        logic [3:0]  seen_tag [3];

        sw_rounds = '{32, 16, 1};
        sw_lat    = '{8, 1, 1};

        nrst = 1'b0; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1;
        in_decrypt = 1'b0; in_tag = '0; in_v0 = '0; in_v1 = '0; in_key = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_v0", out_v0, 32'd0);
        chk("rst_out_v1", out_v1, 32'd0);
        chk("rst_out_tag", out_tag, 4'd0);
        @(posedge clk); #1;
        nrst = 1'b1;

        // Known answer, then its decrypt
        send(1'b0, 4'd5, 32'd0, 32'd0, 128'd0, 32'h41EA3A0A, 32'h94BAA940);
        drain();
        send(1'b1, 4'd9, 32'h41EA3A0A, 32'h94BAA940, 128'd0, 32'd0, 32'd0);
        drain();

        // Back-to-back alternating encrypt / decrypt round trips
        for (int i = 0; i < 32; i++) begin
            p0 = $urandom; p1 = $urandom;
            k = {$urandom, $urandom, $urandom, $urandom};
            c = tea_model(p0, p1, k, 1'b0, STG);
            send(1'b0, 4'(i), p0, p1, k, c[63:32], c[31:0]);
            send(1'b1, 4'(i + 1), c[63:32], c[31:0], k, p0, p1);
        end
        drain();

        // Backpressure with a full pipe
        chk_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 50; i++) send_rand(1'($urandom_range(1)));
                in_valid = 1'b0;
            end
            begin
                repeat (40) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                snap_v0 = out_v0; snap_v1 = out_v1; snap_tag = out_tag;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 1'b0);
                    chk("stall_out_valid", out_valid, 1'b1);
                    chk("stall_v0", out_v0, snap_v0);
                    chk("stall_v1", out_v1, snap_v1);
                    chk("stall_tag", out_tag, snap_tag);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        chk_lat = 1'b1;

        // Bubbles: 1,0,0,1
        send_rand(1'b0);
        h = last_hs;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_rand(1'b1);
        in_valid = 1'b0;
        pat = 4'b1001;
        w = 0;
        while (cyc < h + STG && w < 200) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 4; i++) begin
            chk("bubble_pattern", out_valid, pat[3-i]);
            if (i < 3) @(negedge clk);
        end
        drain();

        // Reset with 20 entries in flight
        for (int i = 0; i < 20; i++) send_rand(1'($urandom_range(1)));
        in_valid = 1'b0;
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_v0", out_v0, 32'd0);
        chk("flush_out_v1", out_v1, 32'd0);
        chk("flush_out_tag", out_tag, 4'd0);
        chk("flush_in_ready", in_ready, 1'b1);
        repeat (50) @(negedge clk);
        @(posedge clk); #1;

        // Other configurations: latency = STAGES and model agreement
        for (int t = 0; t < 4; t++) begin
            p0 = $urandom; p1 = $urandom;
            k = {$urandom, $urandom, $urandom, $urandom};
            in_decrypt = 1'(t % 2); in_tag = 4'(t + 3);
            in_v0 = p0; in_v1 = p1; in_key = k;
            sw_valid = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk("sweep_in_ready", sw_rdy[i], 1'b1);
            h = cyc;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                seen_n[i] = 0; seen_cyc[i] = 0; seen_d[i] = '0; seen_tag[i] = '0;
            end
            repeat (40) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (sw_vld[i]) begin
                        seen_n[i]++;
                        if (seen_n[i] == 1) begin
                            seen_cyc[i] = cyc;
                            seen_d[i]   = {sw_v0[i], sw_v1[i]};
                            seen_tag[i] = sw_tag[i];
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                chk("sweep_count", 64'(seen_n[i]), 64'd1);
                chk("sweep_latency", 64'(seen_cyc[i] - h), 64'(sw_lat[i]));
                chk("sweep_data", seen_d[i], tea_model(p0, p1, k, 1'(t % 2), sw_rounds[i]));
                chk("sweep_tag", seen_tag[i], 4'(t + 3));
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tea_pipe_ed.md
# tea_pipe_ed

Parametrised, fully pipelined TEA block that performs encryption or decryption, selected per transaction. It has a valid/ready handshake with global-stall backpressure and per-transaction keys, tags and mode. It is the successor to the team's fixed 32-cycle encrypt-only TEA pipeline, and sits between the block-cipher front-end (upstream) and the result buffer (downstream).

## Interface
- ROUNDS, 32, TEA cycles per block; each cycle is one v0 half-round plus one v1 half-round; must be ≥ 1.
- RPS, 1, cycles unrolled per pipeline stage; must divide ROUNDS exactly; STAGES = ROUNDS/RPS.
- TAG_W, 4, width of the sideband tag carried with each transaction.
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  pipeline can accept input this cycle.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt.
- in_tag  in  TAG_W  opaque sideband; returned unchanged.
- in_v0, in_v1  in  32 each  data block.
- in_key  in  128  key; k0 = [31:0], k1 = [63:32], k2 = [95:64], k3 = [127:96].
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_decrypt  out  1  mode of the result.
- out_tag  out  TAG_W  tag of the result.
- out_v0, out_v1  out  32 each  result block.

## Operation
- DELTA = 32'h9E3779B9. F(x, s, ka, kb) = ((x<<4)+ka) ^ (x+s) ^ ((x>>5)+kb). All arithmetic is modulo 2^32; shifts are logical.
- Global cycle index g = 0..ROUNDS-1. Stage s applies cycles g = s·RPS .. s·RPS+RPS-1.
- Encrypt, cycle g:
  - sum = DELTA·(g+1)
  - v0 += F(v1, sum, k0, k1)
  - then v1 += F(new v0, sum, k2, k3)
- Decrypt, cycle g:
  - sum = DELTA·(ROUNDS-g)
  - v1 -= F(v0, sum, k2, k3)
  - then v0 -= F(new v1, sum, k0, k1)
- sum is a per-stage elaboration-time constant. It is never pipelined or accumulated at runtime.
- Pipeline ranks 0..STAGES-1. Each rank holds: valid, decrypt, tag, v0, v1, key.
  - Rank 0 captures the rounds of stage 0 applied to the inputs.
  - Rank s captures the rounds of stage s applied to rank s-1.
  - The out_* ports are driven directly from rank STAGES-1.
- Advance: adv = !out_valid || out_ready, and in_ready = adv. in_ready is combinational and does not depend on in_valid.
- When adv = 1, all ranks shift by one. Rank 0 valid takes in_valid; when in_valid = 0 the shifted-in entry is a bubble. Bubbles are not collapsed.
- When adv = 0, all ranks hold, and in_valid is ignored.
- The mode is per transaction. Encrypt and decrypt entries may be freely interleaved back-to-back.

## Timing
- Throughput: one block per cycle while out_ready = 1.
- Latency: a handshake in cycle c gives out_valid = 1 in cycle c+STAGES, provided there is no stall. Each stall cycle adds exactly one cycle.
- Reset: while nrst = 0 at a clock edge, all rank valids and all out_* data are cleared to 0, so out_valid = 0. Consequently in_ready = 1 during and right after reset.
- Reset mid-operation flushes all in-flight transactions. Nothing is emitted for them.
- out_valid = 1 with out_ready = 0: every out_* signal stays stable until the handshake completes.
- Simultaneous output handshake and input handshake in the same cycle is legal; occupancy is unchanged.

## Structure
- Package tea_pkg:
  - constant TEA_DELTA
  - function tea_f
  - function tea_sum(g, rounds, decrypt) returning the constant sum for cycle g
- Sub-module tea_round: purely combinational, one TEA cycle.
  - Inputs: v0, v1, key, decrypt, parameter SUM_ENC, parameter SUM_DEC.
  - tea_pipe_ed instantiates STAGES×RPS copies via generate.
- Elaboration check: fail if ROUNDS % RPS != 0.

## Test plan
- Encrypt known-answer: ROUNDS = 32, RPS = 1, key = 0, v = 0, tag = 5 → out_v0/out_v1 = 41EA3A0A/94BAA940 and out_tag = 5, with out_valid exactly 32 cycles after the handshake.
- Decrypt round-trip: decrypt 41EA3A0A/94BAA940 with key 0 → 00000000/00000000. Then apply back-to-back alternating encrypt/decrypt of 64 random blocks with random keys against a C model → every result matches, one per cycle, in order.
- Backpressure: hold out_ready = 0 for 10 cycles while the pipe is full → in_ready = 0, out_* stable, no loss or duplication. On release, results resume in order.
- Bubbles: drive in_valid in the pattern 1,0,0,1 → out_valid shows the same 1,0,0,1 pattern STAGES cycles later, with correct data.
- Reset mid-flight: pull nrst low for 1 cycle with 20 entries in flight → out_valid = 0 and out_* = 0 the next cycle, and none of the 20 entries ever appears.
- Parameter sweep: (ROUNDS, RPS) = (32, 4), (16, 16), (1, 1) → latency equals STAGES, and results match the C model for that ROUNDS.
